// File: rtl/window_gen_3x3_pkg.sv
// Shared image-pipeline definitions for the 3x3 window interface.
// Window byte i sits at bits [i*PIX_W +: PIX_W], i = 3*row + col; row 0 is the oldest line.
package window_gen_3x3_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_W     = 72;
    localparam int NUM_LINES = 4;
    localparam int WIN_ROWS  = 3;
    localparam int WIN_COLS  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    function automatic int win_byte_idx(input int row, input int col);
        return WIN_COLS * row + col;
    endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One image line of storage: single write port, three adjacent pixels read combinationally.
module line_buffer
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_WIDTH = 512,
    localparam int COL_W = $clog2(IMG_WIDTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [COL_W-1:0]      wr_col,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic [COL_W-1:0]      rd_col,
    output logic [3*PIX_W-1:0]    rd_data
);

    logic [PIX_W-1:0] mem [IMG_WIDTH];
    logic [COL_W-1:0] rd_col_1;
    logic [COL_W-1:0] rd_col_2;

    // Contents are intentionally not reset; valid data is tracked by the fill count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_col] <= wr_data;
        end
    end

    assign rd_col_1 = rd_col + COL_W'(1);
    assign rd_col_2 = rd_col + COL_W'(2);

    always_comb begin
        rd_data = '0;
        rd_data[0*PIX_W +: PIX_W] = mem[rd_col];
        rd_data[1*PIX_W +: PIX_W] = mem[rd_col_1];
        rd_data[2*PIX_W +: PIX_W] = mem[rd_col_2];
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator over four rotating line buffers.
// state | meaning: IDLE | waiting for three resident lines; READ | emitting one window per accepted cycle
module window_gen_3x3
    import window_gen_3x3_pkg::*;
#(
    parameter int IMG_WIDTH = 512
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [PIX_W-1:0]  i_pixel_data,
    input  logic              i_pixel_data_valid,
    output logic              o_ready,
    input  logic              i_out_ready,
    output logic [WIN_W-1:0]  o_pixel_data,
    output logic              o_pixel_data_valid,
    output logic              o_intr
);

    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int FILL_W = $clog2(4 * IMG_WIDTH + 1);

    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(4 * IMG_WIDTH);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(3 * IMG_WIDTH);
    localparam logic [FILL_W-1:0] FILL_LINE  = FILL_W'(IMG_WIDTH);
    localparam logic [COL_W-1:0]  WR_LAST    = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0]  RD_LAST    = COL_W'(IMG_WIDTH - 3);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        wr_line;
    logic [1:0]        rd_line;
    logic [COL_W-1:0]  wr_col;
    logic [COL_W-1:0]  rd_col;
    logic [FILL_W-1:0] fill;
    logic              wr_fire;
    logic              win_fire;
    logic              retire;

    logic [3*PIX_W-1:0] lb_rd   [NUM_LINES];
    logic [1:0]         row_sel [WIN_ROWS];
    logic [3*PIX_W-1:0] row_pix [WIN_ROWS];
    logic [WIN_W-1:0]   window;

    // Refusing writes at 4 lines keeps the writer off the three lines being read.
    assign o_ready = (fill < FILL_MAX);
    assign wr_fire = i_pixel_data_valid && o_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        win_fire  = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (fill >= FILL_START) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (i_out_ready) begin
                    win_fire = 1'b1;
                    if (rd_col == RD_LAST) begin
                        retire    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_col  <= '0;
            wr_line <= '0;
        end else if (wr_fire) begin
            if (wr_col == WR_LAST) begin
                wr_col  <= '0;
                wr_line <= wr_line + 2'd1;
            end else begin
                wr_col <= wr_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill <= '0;
        end else begin
            case ({wr_fire, retire})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_LINE;
                2'b11:   fill <= fill + FILL_W'(1) - FILL_LINE;
                default: fill <= fill;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_col  <= '0;
            rd_line <= '0;
        end else begin
            if (state == IDLE || retire) begin
                rd_col <= '0;
            end else if (win_fire) begin
                rd_col <= rd_col + COL_W'(1);
            end
            if (retire) begin
                rd_line <= rd_line + 2'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pixel_data       <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= win_fire;
            o_intr             <= retire;
            if (win_fire) begin
                o_pixel_data <= window;
            end
        end
    end

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_lines
        line_buffer #(
            .IMG_WIDTH (IMG_WIDTH)
        ) u_line_buffer (
            .clk     (i_clk),
            .wr_en   (wr_fire && (wr_line == 2'(g))),
            .wr_col  (wr_col),
            .wr_data (i_pixel_data),
            .rd_col  (rd_col),
            .rd_data (lb_rd[g])
        );
    end

    // Window row r reads line rd_line + r, wrapping across the four buffers.
    for (genvar r = 0; r < WIN_ROWS; r++) begin : g_rows
        assign row_sel[r] = rd_line + 2'(r);
        assign row_pix[r] = lb_rd[row_sel[r]];
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < WIN_ROWS; r++) begin
            for (int c = 0; c < WIN_COLS; c++) begin
                window[win_byte_idx(r, c)*PIX_W +: PIX_W] = row_pix[r][c*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 with a line-level reference model (IMG_WIDTH = 8).
module tb_window_gen_3x3;

    localparam int W    = 8;
    localparam int NWIN = W - 2;

    typedef struct packed {
        logic [71:0] data;
        logic        intr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix = '0;
    logic        pix_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        ready;
    logic [71:0] win;
    logic        win_valid;
    logic        intr;

    exp_t        q[$];
    logic [7:0]  img [0:63][0:W-1];
    logic [71:0] seen [0:255];
    int          checks = 0;
    int          errors = 0;
    int          accepted = 0;
    int          retired = 0;
    int          nwin = 0;
    logic        prev_or = 1'b0;
    bit          stream_done;

    always #5 clk = ~clk;

    window_gen_3x3 #(.IMG_WIDTH(W)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_pixel_data       (pix),
        .i_pixel_data_valid (pix_valid),
        .o_ready            (ready),
        .i_out_ready        (out_ready),
        .o_pixel_data       (win),
        .o_pixel_data_valid (win_valid),
        .o_intr             (intr)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Window (r0, c0): rows r0..r0+2 and cols c0..c0+2 of the image, byte 3*row+col.
    function automatic logic [71:0] model_window(input int r0, input int c0);
        logic [71:0] w;
        w = '0;
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                w[(3*j+k)*8 +: 8] = img[r0+j][c0+k];
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (win_valid) begin
                check("valid_after_out_ready", {71'd0, prev_or}, 72'd1);
                if (q.size() == 0) begin
                    check("unexpected_window", win, 72'hx);
                end else begin
                    e = q.pop_front();
                    check("window", win, e.data);
                    check("intr_with_window", {71'd0, intr}, {71'd0, e.intr});
                    if (e.intr) retired++;
                end
                if (nwin < 256) seen[nwin] = win;
                nwin++;
            end else begin
                check("intr_idle", {71'd0, intr}, 72'd0);
            end
            check("ready", {71'd0, ready}, {71'd0, ((accepted - retired*W) < 4*W)});
        end
        prev_or = out_ready;
    end

    task automatic model_clear();
        q.delete();
        accepted = 0;
        retired  = 0;
        nwin     = 0;
    endtask

    task automatic do_reset(input bit check_vals);
        pix_valid = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        model_clear();
        #2;
        if (check_vals) begin
            check("rst_valid", {71'd0, win_valid}, 72'd0);
            check("rst_intr",  {71'd0, intr}, 72'd0);
            check("rst_data",  win, 72'd0);
            check("rst_ready", {71'd0, ready}, 72'd1);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        bit acc;
        bit ok;
        int idx;
        pix = d;
        pix_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk);
            if (acc) begin
                ok  = 1'b1;
                idx = accepted;
                img[idx / W][idx % W] = d;
                accepted++;
                if ((idx % W) == W-1 && (idx / W) >= 2) begin
                    for (int c = 0; c < NWIN; c++)
                        q.push_back('{data: model_window(idx/W - 2, c), intr: (c == NWIN-1)});
                end
                break;
            end
        end
        #1;
        if (!ok) check("send_timeout", 72'd0, 72'd1);
    endtask

    task automatic stream(input int n, input bit rnd, input bit gaps);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            d = rnd ? 8'($urandom) : 8'((accepted / W) * 16 + (accepted % W));
            send(d);
        end
        pix_valid = 1'b0;
    endtask

    task automatic drain(input int exp_windows);
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", 72'(q.size()), 72'd0);
        check("window_count", 72'(nwin), 72'(exp_windows));
    endtask

    initial begin
        int n;

        // First line and latency
        do_reset(1'b1);
        out_ready = 1'b1;
        stream(24, 1'b0, 1'b0);
        n = 0;
        while (!win_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 72'(n), 72'd2);
        drain(6);
        check("first_window", seen[0], 72'h22_21_20_12_11_10_02_01_00);
        check("last_window",  seen[5], 72'h27_26_25_17_16_15_07_06_05);

        // Line rotation through all four buffers
        do_reset(1'b0);
        out_ready = 1'b1;
        stream(48, 1'b0, 1'b0);
        drain(24);
        check("group4_first", seen[18], 72'h52_51_50_42_41_40_32_31_30);

        // Backpressure
        do_reset(1'b0);
        fork
            stream(24, 1'b0, 1'b0);
            repeat (80) begin
                @(posedge clk);
                #1 out_ready = ~out_ready;
            end
        join
        out_ready = 1'b1;
        drain(6);
        check("bp_first", seen[0], 72'h22_21_20_12_11_10_02_01_00);

        // Full buffer
        do_reset(1'b0);
        fork
            stream(40, 1'b0, 1'b0);
            begin
                n = 0;
                while (accepted < 32 && n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                repeat (5) @(posedge clk);
                #1;
                check("full_accepted", 72'(accepted), 72'd32);
                check("full_ready_low", {71'd0, ready}, 72'd0);
                out_ready = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    #1;
                    n++;
                end while (!intr && n < 50);
                check("full_intr_seen", {71'd0, intr}, 72'd1);
                check("full_ready_back", {71'd0, ready}, 72'd1);
            end
        join
        drain(18);

        // Reset during the third window
        do_reset(1'b0);
        out_ready = 1'b1;
        stream(24, 1'b0, 1'b0);
        n = 0;
        while (nwin < 3 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("mid_reach_win3", 72'(nwin), 72'd3);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {71'd0, win_valid}, 72'd0);
        check("mid_rst_intr",  {71'd0, intr}, 72'd0);
        check("mid_rst_ready", {71'd0, ready}, 72'd1);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        stream(24, 1'b0, 1'b0);
        drain(6);
        check("mid_first_window", seen[0], 72'h22_21_20_12_11_10_02_01_00);
        check("mid_last_window",  seen[5], 72'h27_26_25_17_16_15_07_06_05);

        // Random pixels, gaps and backpressure
        do_reset(1'b0);
        stream_done = 1'b0;
        fork
            begin
                stream(10*W, 1'b1, 1'b1);
                stream_done = 1'b1;
            end
            while (!stream_done) begin
                @(posedge clk);
                #1 out_ready = 1'($urandom_range(0, 1));
            end
        join
        out_ready = 1'b1;
        drain(8*NWIN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 window generator. It is the producer side of the 72-bit window interface consumed by the 3x3 convolution filters (sharpen, blur, edge). It buffers a raster pixel stream in four rotating line buffers. Once three full lines are resident, it emits one packed 3x3 window per cycle across the line, then retires the oldest line and pulses an interrupt so the DMA/driver can supply the next line.

## Interface
- `IMG_WIDTH`, 512: pixels per line; must be ≥ 4.
- `i_clk`  in  1: clock.
- `i_rst_n`  in  1: asynchronous active-low reset.
- `i_pixel_data`  in  8: upstream pixel, raster order.
- `i_pixel_data_valid`  in  1: upstream pixel valid; a write occurs when valid && `o_ready`.
- `o_ready`  out  1: buffer can accept a pixel.
- `i_out_ready`  in  1: downstream can take a window this cycle.
- `o_pixel_data`  out  72: window; byte `i` is at bits `[i*8+:8]`, `i = 3*row + col`; row 0 is the oldest line, col 0 is leftmost.
- `o_pixel_data_valid`  out  1: window valid, one cycle per window.
- `o_intr`  out  1: one-cycle pulse when a line is retired.

## Operation
- Storage: 4 line buffers × `IMG_WIDTH` × 8 bits.
  - `wr_line` (2 bits) selects the line being written; `wr_col` selects the column.
  - `rd_line` (2 bits) is the oldest resident line; window rows come from `rd_line`, `rd_line+1`, `rd_line+2` (mod 4).
- Write side:
  - Each accepted pixel is stored at (`wr_line`, `wr_col`).
  - `wr_col` wraps at `IMG_WIDTH-1`; on that wrap `wr_line` increments mod 4.
- Fill counter `fill` (range 0..4·`IMG_WIDTH`):
  - +1 per accepted pixel.
  - −`IMG_WIDTH` on retire.
  - Both on the same edge: `fill + 1 − IMG_WIDTH`.
- `o_ready` = (`fill < 4*IMG_WIDTH`), combinational from `fill`. This guarantees writes never overwrite a line under read.
- FSM:
  - **IDLE**:
    - `rd_col` = 0.
    - Go to READ when `fill >= 3*IMG_WIDTH`.
  - **READ**, per cycle with `i_out_ready`=1:
    - Register the window at `rd_col..rd_col+2` from the three read lines.
    - `rd_col` += 1.
    - With `i_out_ready`=0: hold everything and do not assert valid.
    - On the accepted cycle where `rd_col == IMG_WIDTH-3`: this is the last window. Retire the line: `rd_line` += 1 mod 4, `fill` −= `IMG_WIDTH`, pulse `o_intr`, go to IDLE.
- There are `IMG_WIDTH-2` windows per line, with no edge padding.
- Downstream does not stall a window once it is presented. `i_out_ready` gates only the generation of the next window.

## Timing
- Reset values:
  - `o_pixel_data` = 0, `o_pixel_data_valid` = 0, `o_intr` = 0.
  - `fill` = 0, `wr_line` = `wr_col` = `rd_line` = `rd_col` = 0.
  - State = IDLE, so `o_ready` = 1.
  - Buffer contents are not reset.
- Latency: with the last pixel of line 3 written at edge E (fill becomes 3W):
  - State is READ after edge E+1.
  - First `o_pixel_data_valid` is high after edge E+2.
  - With `i_out_ready` held high, valid stays high for W−2 consecutive cycles.
- `o_intr` is high for exactly the one cycle after the retire edge, which coincides with the last window being valid.
- Between lines there is at least one IDLE cycle (one valid-low bubble).
- Reset mid-line, asynchronous: all state returns to reset values immediately; partial lines are discarded.

## Structure
- Shared image package holds:
  - `PIX_W` = 8.
  - `WIN_W` = 72.
  - The window byte-index convention.
  - The FSM state enum {IDLE, READ}.
- Sub-module `line_buffer`:
  - One `IMG_WIDTH`×8 array.
  - Write port.
  - 3-pixel combinational read at `rd_col`.
  - Instantiated 4×.
- A 4:1 mux per window row in the top level.

## Test plan
Bench uses `IMG_WIDTH` = 8, with the pixel at row r, col c = 16r + c.
- **First line.** Stream 24 pixels back-to-back with `i_out_ready`=1.
  - Required: 6 windows; the first is `72'h22_21_20_12_11_10_02_01_00`.
  - Required: the last is `72'h27_26_25_17_16_15_07_06_05`.
  - Required: `o_intr` high with the 6th window only.
- **Latency.** Measure edges from the 24th write to the first valid: exactly 2.
- **Line rotation.** Stream 48 pixels (rows 0–5).
  - Required: 4 line-groups of 6 windows.
  - Required: the first window of group 4 has bytes 0x30..0x52 in the stated order.
  - Required: `rd_line` wraps 3→0 with no corruption.
- **Backpressure.** Toggle `i_out_ready` 1/0 during READ.
  - Required: valid only in cycles following `i_out_ready`=1.
  - Required: still exactly 6 windows, in order, no duplicates.
- **Full.** Hold `i_out_ready`=0 and offer 40 pixels.
  - Required: `o_ready` drops after the 32nd accepted pixel; the 33rd is not written.
  - Raise `i_out_ready`. Required: after the retire, `o_ready` returns the next cycle with `fill` = 24.
- **Reset mid-operation.** Assert `i_rst_n`=0 during window 3.
  - Required: valid and `o_intr` go low immediately, `o_ready`=1.
  - Restream 24 pixels. Required: the first-line results repeat exactly.
